// File: rtl/sh_rl_param.sv
// Parametrised load/shift/rotate register. It steps one bit per clock and reports busy and done.
// Build option SH_ARITH_EN makes shift right fill with the sign bit instead of ser_in.
module sh_rl_param #(
  parameter int WIDTH = 4,
  parameter int IN_W  = 3,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_sh,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [IN_W-1:0]  portB,
  input  logic             ser_in,
  output logic [WIDTH-1:0] sal_sh,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for init_sh; sal_sh holds
  // SHIFT | one step per edge, cnt counts remaining steps down to terminal 1
  // DONE  | one-cycle completion pulse, returns to IDLE

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] sal, sal_n;
  logic             so, so_n;
  logic             fill_r;

`ifdef SH_ARITH_EN
  assign fill_r = sal[WIDTH-1];
`else
  assign fill_r = ser_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_LOAD;
      sal   <= '0;
      so    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      sal   <= sal_n;
      so    <= so_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    sal_n   = sal;
    so_n    = so;
    unique case (state)
      IDLE: begin
        if (init_sh) begin
          if (op == OP_LOAD) begin
            sal_n   = WIDTH'(portB);
            state_n = DONE;
          end else begin
            op_n    = op;
            cnt_n   = amt;
            state_n = (amt == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        unique case (op_q)
          OP_SHR: begin
            sal_n = {fill_r, sal[WIDTH-1:1]};
            so_n  = sal[0];
          end
          OP_SHL: begin
            sal_n = {sal[WIDTH-2:0], ser_in};
            so_n  = sal[WIDTH-1];
          end
          default: begin
            sal_n = {sal[0], sal[WIDTH-1:1]};
            so_n  = sal[0];
          end
        endcase
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sal_sh  = sal;
  assign ser_out = so;
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_sh_rl_param.sv
// Directed bench for sh_rl_param (WIDTH=4, IN_W=3, CNT_W=3) with hand-computed expectations.
module tb_sh_rl_param;

  logic       clk = 1'b0;
  logic       rst, init_sh, ser_in;
  logic [1:0] op;
  logic [2:0] amt;
  logic [2:0] portB;
  logic [3:0] sal_sh;
  logic       ser_out, busy, done;

  int passed = 0;
  int total  = 0;

  sh_rl_param #(.WIDTH(4), .IN_W(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .init_sh(init_sh), .op(op), .amt(amt),
    .portB(portB), .ser_in(ser_in), .sal_sh(sal_sh), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e_sal, input logic e_so,
                           input logic e_busy, input logic e_done);
    chk({tag, ".sal"},  32'(sal_sh),  32'(e_sal));
    chk({tag, ".so"},   32'(ser_out), 32'(e_so));
    chk({tag, ".busy"}, 32'(busy),    32'(e_busy));
    chk({tag, ".done"}, 32'(done),    32'(e_done));
  endtask

  task automatic start(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
    op = o; amt = a; portB = b; init_sh = 1'b1;
    tick();
    init_sh = 1'b0; op = 2'b00; amt = 3'd0; portB = 3'd0;
  endtask

  logic [3:0] exp_sr;

  initial begin
    rst = 1'b1; init_sh = 1'b0; op = 2'b00; amt = 3'd0; portB = 3'd0; ser_in = 1'b0;
    #1;
    repeat (5) tick();
    chk_state("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_state("idle_hold", 4'b0000, 1'b0, 1'b0, 1'b0);

    // 1: load 5
    start(2'b00, 3'd0, 3'd5);
    chk_state("load.k1", 4'b0101, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("load.k2", 4'b0101, 1'b0, 1'b0, 1'b0);

    // 2: shift right by 1
    ser_in = 1'b0;
    start(2'b01, 3'd1, 3'd0);
    chk_state("shr1.k", 4'b0101, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("shr1.k1", 4'b0010, 1'b1, 1'b0, 1'b1);
    tick();
    chk_state("shr1.k2", 4'b0010, 1'b1, 1'b0, 1'b0);

    // 3: reload, shift left by 2
    start(2'b00, 3'd0, 3'd5);
    tick();
    start(2'b10, 3'd2, 3'd0);
    tick();
    chk_state("shl2.k1", 4'b1010, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("shl2.k2", 4'b0100, 1'b1, 1'b0, 1'b1);
    tick();
    chk("shl2.k3.done", 32'(done), 32'd0);

    // 4: reload, rotate right by 5 with ignored init pulses
    start(2'b00, 3'd0, 3'd5);
    tick();
    start(2'b11, 3'd5, 3'd0);
    tick();
    chk_state("rot5.k1", 4'b1010, 1'b1, 1'b1, 1'b0);
    op = 2'b00; portB = 3'd3; init_sh = 1'b1;
    tick();
    tick();
    init_sh = 1'b0; portB = 3'd0;
    chk_state("rot5.k3", 4'b1010, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("rot5.k4", 4'b0101, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("rot5.k5", 4'b1010, 1'b1, 1'b0, 1'b1);
    tick();
    chk_state("rot5.k6", 4'b1010, 1'b1, 1'b0, 1'b0);

    // 5: shift right from 1010, then amt=0
`ifdef SH_ARITH_EN
    exp_sr = 4'b1101;
`else
    exp_sr = 4'b0101;
`endif
    ser_in = 1'b0;
    start(2'b01, 3'd1, 3'd0);
    tick();
    chk_state("sr_fill", exp_sr, 1'b0, 1'b0, 1'b1);
    tick();
    start(2'b11, 3'd0, 3'd0);
    chk_state("amt0.k1", exp_sr, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("amt0.k2", exp_sr, 1'b0, 1'b0, 1'b0);

    // ser_in sampled live during left shift: 0101 -> 1011 -> 0111
    start(2'b00, 3'd0, 3'd5);
    tick();
    ser_in = 1'b1;
    start(2'b10, 3'd2, 3'd0);
    tick();
    chk("shl_ser.k1", 32'(sal_sh), 32'(4'b1011));
    tick();
    chk_state("shl_ser.k2", 4'b0111, 1'b1, 1'b0, 1'b1);
    tick();
    ser_in = 1'b0;

    // 6: abort long shift with reset after 3 steps
    start(2'b10, 3'd7, 3'd0);
    repeat (3) tick();
    chk("abort.pre.busy", 32'(busy), 32'd1);
    chk("abort.pre.sal", 32'(sal_sh), 32'(4'b1000));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("abort.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort.nodone", 32'({done, busy}), 32'd0);
    end
    chk("abort.sal_hold", 32'(sal_sh), 32'd0);

    // reset beats simultaneous init
    rst = 1'b1;
    start(2'b00, 3'd0, 3'd7);
    rst = 1'b0;
    chk_state("rst_vs_init", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
